// File: rtl/tester_common_pkg.sv
// Shared types for the speed-tester generator blocks.
package tester_common;

  localparam int unsigned COUNT_WIDTH = 48;

  typedef logic [15:0] frame_size_t;

  typedef struct packed {
    frame_size_t frame_size;
    logic [15:0] ifg_cycles;
  } port_config_t;

  typedef logic [COUNT_WIDTH-1:0] count_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } sequencer_state_t;

endpackage

// File: rtl/tx_test_sequencer_port_tx_counter.sv
// Per-port frame/byte counter pair fed from a generator AXIS tap.
module port_tx_counter
  import tester_common::*;
#(
  parameter int unsigned CNT_WIDTH = 48
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 active,
  input  logic                 enabled,
  input  logic                 tap_valid,
  input  logic                 tap_ready,
  input  logic                 tap_last,
  input  frame_size_t          frame_size,
  output logic [CNT_WIDTH-1:0] frame_count,
  output logic [CNT_WIDTH-1:0] byte_count
);

  logic                 w_hit;
  logic [CNT_WIDTH-1:0] r_frames;
  logic [CNT_WIDTH-1:0] r_bytes;

  assign w_hit = active & enabled & tap_valid & tap_ready & tap_last;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_frames <= '0;
      r_bytes  <= '0;
    end else if (w_hit) begin
      r_frames <= r_frames + 1'b1;
      r_bytes  <= r_bytes + CNT_WIDTH'(frame_size);
    end
  end

  assign frame_count = r_frames;
  assign byte_count  = r_bytes;

endmodule

// File: rtl/tx_test_sequencer.sv
// Run controller: launches enabled generators together, times the run, drains, and counts traffic.
module tx_test_sequencer
  import tester_common::*;
#(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned DUR_WIDTH = 32,
  parameter int unsigned CNT_WIDTH = 48
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                cmd_start,
  input  logic                                cmd_abort,
  input  logic [DUR_WIDTH-1:0]                duration,
  input  logic [NUM_PORTS-1:0]                port_enable,
  input  port_config_t [NUM_PORTS-1:0]        port_config_in,
  output logic                                busy,
  output logic                                done,
  output port_config_t [NUM_PORTS-1:0]        gen_config,
  input  logic [NUM_PORTS-1:0]                gen_ready,
  output logic [NUM_PORTS-1:0]                gen_start,
  output logic [NUM_PORTS-1:0]                gen_stop,
  input  logic [NUM_PORTS-1:0]                tap_valid,
  input  logic [NUM_PORTS-1:0]                tap_ready,
  input  logic [NUM_PORTS-1:0]                tap_last,
  output logic [NUM_PORTS-1:0][CNT_WIDTH-1:0] frame_count,
  output logic [NUM_PORTS-1:0][CNT_WIDTH-1:0] byte_count,
  output logic [DUR_WIDTH-1:0]                run_cycles
);

  sequencer_state_t             r_state;
  logic [NUM_PORTS-1:0]         r_en;
  port_config_t [NUM_PORTS-1:0] r_cfg;
  logic [DUR_WIDTH-1:0]         r_dur;
  logic [DUR_WIDTH-1:0]         r_timer;
  logic [DUR_WIDTH-1:0]         r_run_cycles;
  logic                         r_drain_first;
  logic                         r_busy;
  logic                         r_done;
  logic [NUM_PORTS-1:0]         r_gen_start;
  logic [NUM_PORTS-1:0]         r_gen_stop;

  logic                         w_accept;
  logic                         w_all_ready;
  logic                         w_counting;
  logic [DUR_WIDTH-1:0]         w_dur_load;

  assign w_accept    = (r_state == ST_IDLE) && cmd_start && (|port_enable);
  assign w_all_ready = ((gen_ready & r_en) == r_en);
  assign w_counting  = (r_state == ST_LAUNCH) || (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign w_dur_load  = (r_dur == '0) ? DUR_WIDTH'(1) : r_dur;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_en          <= '0;
      r_cfg         <= '0;
      r_dur         <= '0;
      r_timer       <= '0;
      r_run_cycles  <= '0;
      r_drain_first <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_gen_start   <= '0;
      r_gen_stop    <= '0;
    end else begin
      r_gen_start <= '0;
      r_gen_stop  <= '0;
      r_done      <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_en         <= port_enable;
            r_cfg        <= port_config_in;
            r_dur        <= duration;
            r_run_cycles <= '0;
            r_busy       <= 1'b1;
            r_state      <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          if (cmd_abort) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else if (w_all_ready) begin
            r_gen_start <= r_en;
            r_timer     <= w_dur_load;
            r_state     <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_run_cycles <= r_run_cycles + 1'b1;
          // Timer holds the cycles left including this one, so 1 marks the last RUN cycle.
          if ((r_timer == DUR_WIDTH'(1)) || cmd_abort) begin
            r_gen_stop    <= r_en;
            r_drain_first <= 1'b1;
            r_state       <= ST_DRAIN;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        ST_DRAIN: begin
          if (r_drain_first) begin
            r_drain_first <= 1'b0;
          end else if (w_all_ready) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    port_tx_counter #(
      .CNT_WIDTH(CNT_WIDTH)
    ) u_cnt (
      .clk        (clk),
      .rst        (rst),
      .clr        (w_accept),
      .active     (w_counting),
      .enabled    (r_en[g]),
      .tap_valid  (tap_valid[g]),
      .tap_ready  (tap_ready[g]),
      .tap_last   (tap_last[g]),
      .frame_size (r_cfg[g].frame_size),
      .frame_count(frame_count[g]),
      .byte_count (byte_count[g])
    );
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign gen_config = r_cfg;
  assign gen_start  = r_gen_start;
  assign gen_stop   = r_gen_stop;
  assign run_cycles = r_run_cycles;

endmodule
